// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter for the UART transmit write port.
// An owner keeps the port until its last byte or an idle timeout.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int DBIT    = 8,
   parameter int TMO     = 1024,
   parameter int TMO_BIT = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DBIT-1:0] data,
   input  logic [NREQ-1:0]      last,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      grant,
   output logic                 timeout,
   input  logic                 tx_full,
   output logic                 wr_uart,
   output logic [DBIT-1:0]      w_data
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [NREQ-1:0]    r_grant;
   logic [NREQ-1:0]    w_grant_nx;
   logic [IW-1:0]      r_owner;
   logic [IW-1:0]      w_owner_nx;
   logic [IW-1:0]      r_ptr;
   logic [IW-1:0]      w_ptr_nx;
   logic [IW-1:0]      w_next_ptr;
   logic [IW-1:0]      w_win;
   logic [IW:0]        w_idx;
   logic               w_found;
   logic [TMO_BIT-1:0] r_cnt;
   logic [TMO_BIT-1:0] w_cnt_nx;
   logic               w_req_g;
   logic               w_last_g;

   assign grant    = r_grant;
   assign w_req_g  = req[r_owner];
   assign w_last_g = last[r_owner];
   assign w_data   = data[int'(r_owner)*DBIT +: DBIT];

   assign w_next_ptr = (r_owner == IW'(NREQ-1)) ? '0 : r_owner + IW'(1);

   // First set req bit searching upward from ptr, wrapping modulo NREQ.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = {1'b0, r_ptr} + (IW+1)'(k);
         if (w_idx >= (IW+1)'(NREQ)) begin
            w_idx = w_idx - (IW+1)'(NREQ);
         end
         if (!w_found && req[w_idx[IW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[IW-1:0];
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_grant_nx = r_grant;
      w_owner_nx = r_owner;
      w_ptr_nx   = r_ptr;
      w_cnt_nx   = r_cnt;
      wr_uart    = 1'b0;
      ack        = '0;
      timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nx = S_BUSY;
               w_grant_nx = NREQ'(1) << w_win;
               w_owner_nx = w_win;
               w_cnt_nx   = '0;
            end
         end
         S_BUSY: begin
            if (w_req_g) begin
               // Backpressure holds the counter so tx_full never times out.
               if (!tx_full) begin
                  wr_uart  = 1'b1;
                  ack      = NREQ'(1) << r_owner;
                  w_cnt_nx = '0;
                  if (w_last_g) begin
                     w_state_nx = S_IDLE;
                     w_grant_nx = '0;
                     w_ptr_nx   = w_next_ptr;
                  end
               end
            end else if (r_cnt == TMO_BIT'(TMO-1)) begin
               timeout    = 1'b1;
               w_state_nx = S_IDLE;
               w_grant_nx = '0;
               w_ptr_nx   = w_next_ptr;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + TMO_BIT'(1);
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_grant_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_grant <= w_grant_nx;
         r_owner <= w_owner_nx;
         r_ptr   <= w_ptr_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, messages, round-robin,
// backpressure, timeout and non-owner hold.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int DBIT = 8;

   logic                 clk;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ*DBIT-1:0] data;
   logic [NREQ-1:0]      last;
   logic [NREQ-1:0]      ack;
   logic [NREQ-1:0]      grant;
   logic                 timeout;
   logic                 tx_full;
   logic                 wr_uart;
   logic [DBIT-1:0]      w_data;

   int errors = 0;
   int checks = 0;

   uart_tx_arbiter #(
      .NREQ(NREQ), .DBIT(DBIT), .TMO(1024), .TMO_BIT(10)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .data(data), .last(last),
      .ack(ack), .grant(grant), .timeout(timeout), .tx_full(tx_full),
      .wr_uart(wr_uart), .w_data(w_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_lane(input int i, input logic [7:0] d, input logic l);
      data[i*DBIT +: DBIT] = d;
      last[i] = l;
   endtask

   task automatic drive();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (grant !== 4'b0000) begin
         errors++; $display("FAIL reset_grant: got %b want 0000", grant);
      end
      checks++;
      if (ack !== 4'b0000) begin
         errors++; $display("FAIL reset_ack: got %b want 0000", ack);
      end
      checks++;
      if (wr_uart !== 1'b0) begin
         errors++; $display("FAIL reset_wr: got %b want 0", wr_uart);
      end
      checks++;
      if (timeout !== 1'b0) begin
         errors++; $display("FAIL reset_tmo: got %b want 0", timeout);
      end
      reset = 1'b1;
   endtask

   task automatic test_single();
      logic [7:0] bytes [3];
      bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
      drive();
      req = 4'b0010;
      set_lane(1, bytes[0], 1'b0);
      @(negedge clk);
      checks++;
      if (wr_uart !== 1'b0 || grant !== 4'b0000) begin
         errors++;
         $display("FAIL single_idle: wr=%b grant=%b want 0/0000", wr_uart, grant);
      end
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         checks++;
         if (grant !== 4'b0010 || wr_uart !== 1'b1 || w_data !== bytes[b]
             || ack !== 4'b0010) begin
            errors++;
            $display("FAIL single_byte%0d: grant=%b wr=%b data=%h ack=%b want 0010/1/%h/0010",
                     b, grant, wr_uart, w_data, ack, bytes[b]);
         end
         drive();
         if (b < 2) set_lane(1, bytes[b+1], b == 1);
         else begin
            req = 4'b0000;
            set_lane(1, 8'h00, 1'b0);
         end
      end
      @(negedge clk);
      checks++;
      if (grant !== 4'b0000 || wr_uart !== 1'b0) begin
         errors++;
         $display("FAIL single_release: grant=%b wr=%b want 0000/0", grant, wr_uart);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] pos;
      logic [3:0] acked;
      logic [7:0] eb;
      int n;
      int er;
      int last_c;
      do_reset();
      drive();
      pos = '0;
      n = 0;
      last_c = 0;
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_lane(i, 8'hA0 | 8'(i), 1'b0);
      for (int c = 0; c < 80 && n < 10; c++) begin
         @(negedge clk);
         acked = ack;
         if (wr_uart) begin
            er = (n / 2) % 4;
            eb = (((n % 2) == 1) ? 8'hB0 : 8'hA0) | 8'(er);
            checks++;
            if (w_data !== eb || ack !== (4'b0001 << er)) begin
               errors++;
               $display("FAIL rr_byte%0d: data=%h ack=%b want %h/%b",
                        n, w_data, ack, eb, 4'b0001 << er);
            end
            if (n > 0) begin
               checks++;
               if ((c - last_c) != (((n % 2) == 1) ? 1 : 2)) begin
                  errors++;
                  $display("FAIL rr_gap%0d: got %0d want %0d",
                           n, c - last_c, ((n % 2) == 1) ? 1 : 2);
               end
            end
            last_c = c;
            n++;
         end
         drive();
         for (int i = 0; i < NREQ; i++) begin
            if (acked[i]) begin
               pos[i] = ~pos[i];
               set_lane(i, (pos[i] ? 8'hB0 : 8'hA0) | 8'(i), pos[i]);
            end
         end
      end
      req = 4'b0000;
      last = 4'b0000;
      checks++;
      if (n != 10) begin
         errors++; $display("FAIL rr_count: got %0d want 10", n);
      end
   endtask

   task automatic test_backpressure();
      int bad_wr;
      int bad_ack;
      int bad_tmo;
      int bad_grant;
      bad_wr = 0; bad_ack = 0; bad_tmo = 0; bad_grant = 0;
      drive();
      req = 4'b1000;
      set_lane(3, 8'hC1, 1'b0);
      @(negedge clk);
      drive();
      @(negedge clk);
      checks++;
      if (wr_uart !== 1'b1 || w_data !== 8'hC1 || ack !== 4'b1000) begin
         errors++;
         $display("FAIL bp_first: wr=%b data=%h ack=%b want 1/c1/1000",
                  wr_uart, w_data, ack);
      end
      drive();
      set_lane(3, 8'hC2, 1'b1);
      tx_full = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (wr_uart !== 1'b0) bad_wr++;
         if (ack !== 4'b0000) bad_ack++;
         if (timeout !== 1'b0) bad_tmo++;
         if (grant !== 4'b1000) bad_grant++;
      end
      checks++;
      if (bad_wr != 0) begin
         errors++; $display("FAIL bp_wr: got %0d writes want 0", bad_wr);
      end
      checks++;
      if (bad_ack != 0) begin
         errors++; $display("FAIL bp_ack: got %0d acks want 0", bad_ack);
      end
      checks++;
      if (bad_tmo != 0) begin
         errors++; $display("FAIL bp_timeout: got %0d pulses want 0", bad_tmo);
      end
      checks++;
      if (bad_grant != 0) begin
         errors++; $display("FAIL bp_grant: lost grant %0d cycles want 0", bad_grant);
      end
      drive();
      tx_full = 1'b0;
      @(negedge clk);
      checks++;
      if (wr_uart !== 1'b1 || w_data !== 8'hC2 || ack !== 4'b1000) begin
         errors++;
         $display("FAIL bp_resume: wr=%b data=%h ack=%b want 1/c2/1000",
                  wr_uart, w_data, ack);
      end
      drive();
      req = 4'b0000;
      last = 4'b0000;
   endtask

   task automatic test_timeout();
      int t_seen;
      t_seen = 0;
      drive();
      req = 4'b0011;
      set_lane(0, 8'hD0, 1'b0);
      set_lane(1, 8'hE1, 1'b1);
      @(negedge clk);
      drive();
      @(negedge clk);
      checks++;
      if (wr_uart !== 1'b1 || w_data !== 8'hD0 || ack !== 4'b0001) begin
         errors++;
         $display("FAIL tmo_first: wr=%b data=%h ack=%b want 1/d0/0001",
                  wr_uart, w_data, ack);
      end
      drive();
      req = 4'b0010;
      for (int t = 1; t <= 1100 && t_seen == 0; t++) begin
         @(negedge clk);
         if (timeout === 1'b1) t_seen = t;
      end
      checks++;
      if (t_seen != 1024) begin
         errors++; $display("FAIL tmo_latency: got %0d want 1024", t_seen);
      end
      drive();
      @(negedge clk);
      checks++;
      if (timeout !== 1'b0 || grant !== 4'b0000) begin
         errors++;
         $display("FAIL tmo_release: tmo=%b grant=%b want 0/0000", timeout, grant);
      end
      drive();
      @(negedge clk);
      checks++;
      if (grant !== 4'b0010 || wr_uart !== 1'b1 || w_data !== 8'hE1) begin
         errors++;
         $display("FAIL tmo_next: grant=%b wr=%b data=%h want 0010/1/e1",
                  grant, wr_uart, w_data);
      end
      drive();
      req = 4'b0000;
      last = 4'b0000;
   endtask

   task automatic test_hold();
      int ack0;
      ack0 = 0;
      drive();
      req = 4'b0100;
      set_lane(2, 8'hF1, 1'b0);
      @(negedge clk);
      drive();
      req = 4'b0101;
      set_lane(0, 8'h55, 1'b1);
      @(negedge clk);
      if (ack[0]) ack0++;
      checks++;
      if (w_data !== 8'hF1 || ack !== 4'b0100) begin
         errors++;
         $display("FAIL hold_f1: data=%h ack=%b want f1/0100", w_data, ack);
      end
      drive();
      set_lane(2, 8'hF2, 1'b1);
      @(negedge clk);
      if (ack[0]) ack0++;
      checks++;
      if (w_data !== 8'hF2 || ack !== 4'b0100) begin
         errors++;
         $display("FAIL hold_f2: data=%h ack=%b want f2/0100", w_data, ack);
      end
      drive();
      req = 4'b0001;
      set_lane(2, 8'h00, 1'b0);
      @(negedge clk);
      if (ack[0]) ack0++;
      drive();
      @(negedge clk);
      if (ack[0]) ack0++;
      checks++;
      if (grant !== 4'b0001 || w_data !== 8'h55 || ack !== 4'b0001) begin
         errors++;
         $display("FAIL hold_55: grant=%b data=%h ack=%b want 0001/55/0001",
                  grant, w_data, ack);
      end
      drive();
      req = 4'b0000;
      last = 4'b0000;
      @(negedge clk);
      if (ack[0]) ack0++;
      checks++;
      if (ack0 != 1) begin
         errors++; $display("FAIL hold_ack0: got %0d pulses want 1", ack0);
      end
   endtask

   task automatic test_reset_mid();
      drive();
      req = 4'b0100;
      set_lane(2, 8'h77, 1'b0);
      @(negedge clk);
      drive();
      @(negedge clk);
      checks++;
      if (grant !== 4'b0100 || wr_uart !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_busy: grant=%b wr=%b want 0100/1", grant, wr_uart);
      end
      drive();
      req = 4'b0101;
      set_lane(2, 8'h78, 1'b0);
      set_lane(0, 8'h99, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (grant !== 4'b0000 || ack !== 4'b0000 || wr_uart !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_clear: grant=%b ack=%b wr=%b want 0000/0000/0",
                  grant, ack, wr_uart);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001 || w_data !== 8'h99 || ack !== 4'b0001) begin
         errors++;
         $display("FAIL rstmid_regrant: grant=%b data=%h ack=%b want 0001/99/0001",
                  grant, w_data, ack);
      end
      drive();
      req = 4'b0000;
      last = 4'b0000;
   endtask

   initial begin
      reset = 1'b0;
      req = '0;
      data = '0;
      last = '0;
      tx_full = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_hold();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single write port of the UART transmit path (wr_uart / w_data / tx_full) among NREQ requesters.
- Arbitration is round-robin at message granularity. Once granted, a requester keeps the port until it writes a byte flagged last, so messages never interleave on the serial line.
- An idle timeout reclaims the port from a requester that stalls mid-message.
- Sits between client logic (command responders, status reporters) and the uart block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DBIT, 8, data word width; matches the UART data bits
- TMO, 1024, idle cycles allowed mid-message before forced release
- TMO_BIT, 10, width of the timeout counter; 2^TMO_BIT >= TMO

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  reset; asynchronous, active-low
- req  in  NREQ  req[i]=1: requester i has a byte valid on its data lane
- data  in  NREQ*DBIT  lane i = data[i*DBIT +: DBIT]
- last  in  NREQ  last[i]=1: current byte of requester i ends its message
- ack  out  NREQ  one-cycle pulse; byte of requester i accepted this cycle
- grant  out  NREQ  one-hot owner of the port; all-zero when idle
- timeout  out  1  one-cycle pulse when a forced release occurs
- tx_full  in  1  from uart; TX FIFO full
- wr_uart  out  1  to uart; write strobe
- w_data  out  DBIT  to uart; byte to write

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State machine to IDLE.
  - grant=0, owner index=0, priority pointer ptr=0 (requester 0 searched first), timeout counter=0, timeout=0.
  - ack=0 and wr_uart=0, since both are combinational from state.
- States: IDLE and BUSY.
- IDLE:
  - If any req bit is set, select the first set bit found searching from ptr upward, wrapping modulo NREQ.
  - Next cycle: state=BUSY, grant=onehot(winner), counter cleared.
  - No byte is written in the IDLE cycle, so grant latency is 1 cycle from req.
- BUSY, owner g:
  - wr_uart = req[g] & ~tx_full. w_data = lane g. ack[g] = wr_uart.
  - All other ack bits are 0.
  - w_data is don't-care when wr_uart=0; it is still driven from lane g.
- BUSY, accept with last[g]=1:
  - Next cycle: state=IDLE, grant=0, ptr=(g+1) mod NREQ.
  - Another requester can therefore win one cycle later. Back-to-back messages from different requesters have a 2-cycle gap between the last byte and the first new byte.
- BUSY, accept with last[g]=0: stay BUSY, counter cleared.
- BUSY, req[g]=0:
  - Counter increments.
  - When the counter reaches TMO-1 and req[g] is still 0: timeout pulses for 1 cycle, state goes to IDLE, grant=0, ptr=(g+1) mod NREQ.
  - The abandoned message is not terminated; the client is responsible for that.
- BUSY, req[g]=1 and tx_full=1:
  - Backpressure: no write, no ack, counter held (not incremented).
  - tx_full never causes a timeout.
- Requests from non-owners are ignored while BUSY. They must hold req and data until they receive their own ack.
- Requester obligations: data and last must stay stable while req=1 and ack=0. Dropping req without an ack is legal; the owner resumes with its next byte.
- Round-robin fairness: with all requesters continuously requesting, grant order is 0,1,…,NREQ-1,0,…
- A single continuously-requesting requester is regranted after each message, with a 1-cycle IDLE gap.
- Reset mid-message: outputs clear asynchronously and no further writes occur. Bytes already in the UART FIFO are unaffected.
- Invariants:
  - wr_uart is never 1 while tx_full is 1.
  - At most one ack bit is set in any cycle.
  - grant is one-hot or zero.

Test Plan:
- Reset: reset=0 mid-message with req[2]=1 → grant=0, ack=0, wr_uart=0 immediately. After release, the first grant goes to the lowest set req starting from 0.
- Single message: req[1]=1 sending 0x41,0x42,0x43 (last on 0x43), tx_full=0 → grant=0010 one cycle after req, three consecutive wr_uart pulses with w_data 0x41,0x42,0x43, ack[1] on each, grant=0 the cycle after.
- Round-robin: req=1111, each sends a 2-byte message → message order on w_data is from requesters 0,1,2,3,0. No byte of requester j appears between bytes of requester i.
- Backpressure: owner 3 mid-message, tx_full=1 for 2000 cycles → wr_uart=0, ack=0, timeout never pulses. After tx_full=0, the next byte is written in the same cycle.
- Timeout: owner 0 sends 1 non-last byte then drops req, TMO=1024 → timeout pulses exactly 1024 cycles after the last ack, grant clears, and pending req[1] is granted on the following cycle.
- Non-owner hold: owner 2 busy while req[0]=1 with data 0x55 → ack[0] stays 0 until 2 finishes, then 0x55 is written and ack[0] pulses once.
